// File: rtl/servisia_mem_checker.sv
// rtl/servisia_mem_checker.sv - lockstep read-data checker against a shadow reference memory
//
// Compares per-channel DUT read data with reference read data READ_LATENCY
// cycles after each accepted read, and keeps sticky per-channel error flags,
// a saturating mismatch count and an optional first-mismatch record.
//
// Optional feature macro: SERVISIA_MEMCHK_CAPTURE_EN builds the cap_* registers;
// without it the cap_* outputs are tied to 0.
//
// Ports:
//   clk_i          clock, rising edge
//   rst_i          asynchronous active-high reset
//   en_i           check enable, sampled with ren_i at issue
//   clear_i        synchronous clear of flags, counter, capture and HALTED state
//   halt_on_err_i  stop checking after the first mismatch
//   ren_i          per-channel read strobe
//   raddr_i        per-channel read address, channel c at [c*ADDR_W +: ADDR_W]
//   dut_rdata_i    DUT read data, packed per channel
//   ref_rdata_i    reference read data, packed per channel
//   checking_o     high while in CHECKING
//   err_o          sticky OR of err_ch_o
//   err_ch_o       per-channel sticky mismatch flags
//   mismatch_cnt_o saturating mismatch count
//   cap_*_o        first-mismatch record (valid, channel, address, DUT data, ref data)

module servisia_mem_checker #(
    parameter int NUM_CH        = 1,
    parameter int ADDR_W        = 20,
    parameter int DATA_W        = 8,
    parameter int READ_LATENCY  = 1,
    parameter int WARMUP_CYCLES = 0,
    parameter int CNT_W         = 16,
    localparam int CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     en_i,
    input  logic                     clear_i,
    input  logic                     halt_on_err_i,
    input  logic [NUM_CH-1:0]        ren_i,
    input  logic [NUM_CH*ADDR_W-1:0] raddr_i,
    input  logic [NUM_CH*DATA_W-1:0] dut_rdata_i,
    input  logic [NUM_CH*DATA_W-1:0] ref_rdata_i,
    output logic                     checking_o,
    output logic                     err_o,
    output logic [NUM_CH-1:0]        err_ch_o,
    output logic [CNT_W-1:0]         mismatch_cnt_o,
    output logic                     cap_valid_o,
    output logic [CH_W-1:0]          cap_ch_o,
    output logic [ADDR_W-1:0]        cap_addr_o,
    output logic [DATA_W-1:0]        cap_dut_o,
    output logic [DATA_W-1:0]        cap_ref_o
);

    localparam int PC_W   = $clog2(NUM_CH + 1);
    localparam int WC_W   = (WARMUP_CYCLES > 1) ? $clog2(WARMUP_CYCLES) : 1;
    localparam int W_INIT = (WARMUP_CYCLES > 0) ? WARMUP_CYCLES - 1 : 0;
    localparam logic [CNT_W+PC_W-1:0] CNT_MAX = {{PC_W{1'b0}}, {CNT_W{1'b1}}};

    typedef enum logic [1:0] {ST_WARMUP, ST_CHECKING, ST_HALTED} state_t;
    localparam state_t RST_STATE = (WARMUP_CYCLES > 0) ? ST_WARMUP : ST_CHECKING;

    state_t                  state;
    state_t                  state_nxt;
    logic [WC_W-1:0]         warm_cnt;
    logic [READ_LATENCY-1:0] pipe_v [NUM_CH];
    logic [NUM_CH-1:0]       mis;
    logic                    any_mis;
    logic [PC_W-1:0]         pop;
    logic [CNT_W+PC_W-1:0]   cnt_sum;

    // Valid-bit issue pipeline; its last stage marks the compare cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int c = 0; c < NUM_CH; c++) pipe_v[c] <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                pipe_v[c][0] <= ren_i[c] & en_i;
                for (int s = 1; s < READ_LATENCY; s++) pipe_v[c][s] <= pipe_v[c][s-1];
            end
        end
    end

    // Mismatches only count in CHECKING; reads maturing in other states are dropped.
    always_comb begin
        mis = '0;
        pop = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            mis[c] = pipe_v[c][READ_LATENCY-1] && (state == ST_CHECKING) &&
                     (dut_rdata_i[c*DATA_W +: DATA_W] != ref_rdata_i[c*DATA_W +: DATA_W]);
            pop = pop + PC_W'(mis[c]);
        end
        any_mis = |mis;
        cnt_sum = {{PC_W{1'b0}}, mismatch_cnt_o} + {{CNT_W{1'b0}}, pop};
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_WARMUP:   if (warm_cnt == '0) state_nxt = ST_CHECKING;
            ST_CHECKING: if (halt_on_err_i && any_mis && !clear_i) state_nxt = ST_HALTED;
            ST_HALTED:   if (clear_i) state_nxt = ST_CHECKING;
            default:     state_nxt = ST_CHECKING;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= RST_STATE;
            warm_cnt <= WC_W'(W_INIT);
        end else begin
            state <= state_nxt;
            if (state == ST_WARMUP && warm_cnt != '0) warm_cnt <= warm_cnt - 1'b1;
        end
    end

    assign checking_o = (state == ST_CHECKING);

    // Clear has priority, so a mismatch in the clear cycle is discarded.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_ch_o       <= '0;
            mismatch_cnt_o <= '0;
        end else if (clear_i) begin
            err_ch_o       <= '0;
            mismatch_cnt_o <= '0;
        end else if (any_mis) begin
            err_ch_o       <= err_ch_o | mis;
            mismatch_cnt_o <= (cnt_sum > CNT_MAX) ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];
        end
    end

    assign err_o = |err_ch_o;

`ifdef SERVISIA_MEMCHK_CAPTURE_EN
    logic [ADDR_W-1:0] pipe_a [NUM_CH][READ_LATENCY];
    logic [CH_W-1:0]   first_ch;
    logic [ADDR_W-1:0] first_addr;
    logic [DATA_W-1:0] first_dut;
    logic [DATA_W-1:0] first_ref;
    logic              found;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int c = 0; c < NUM_CH; c++)
                for (int s = 0; s < READ_LATENCY; s++) pipe_a[c][s] <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                pipe_a[c][0] <= raddr_i[c*ADDR_W +: ADDR_W];
                for (int s = 1; s < READ_LATENCY; s++) pipe_a[c][s] <= pipe_a[c][s-1];
            end
        end
    end

    // Lowest-indexed mismatching channel wins the capture.
    always_comb begin
        first_ch   = '0;
        first_addr = '0;
        first_dut  = '0;
        first_ref  = '0;
        found      = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (mis[c] && !found) begin
                found      = 1'b1;
                first_ch   = CH_W'(c);
                first_addr = pipe_a[c][READ_LATENCY-1];
                first_dut  = dut_rdata_i[c*DATA_W +: DATA_W];
                first_ref  = ref_rdata_i[c*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cap_valid_o <= 1'b0;
            cap_ch_o    <= '0;
            cap_addr_o  <= '0;
            cap_dut_o   <= '0;
            cap_ref_o   <= '0;
        end else if (clear_i) begin
            cap_valid_o <= 1'b0;
            cap_ch_o    <= '0;
            cap_addr_o  <= '0;
            cap_dut_o   <= '0;
            cap_ref_o   <= '0;
        end else if (found && !cap_valid_o) begin
            cap_valid_o <= 1'b1;
            cap_ch_o    <= first_ch;
            cap_addr_o  <= first_addr;
            cap_dut_o   <= first_dut;
            cap_ref_o   <= first_ref;
        end
    end
`else
    logic unused_raddr;
    assign unused_raddr = ^raddr_i;
    assign cap_valid_o  = 1'b0;
    assign cap_ch_o     = '0;
    assign cap_addr_o   = '0;
    assign cap_dut_o    = '0;
    assign cap_ref_o    = '0;
`endif

endmodule

// File: tb/tb_servisia_mem_checker.sv
// tb/tb_servisia_mem_checker.sv - directed self-checking bench for servisia_mem_checker

module tb_servisia_mem_checker;

    localparam int NUM_CH = 4;
    localparam int ADDR_W = 20;
    localparam int DATA_W = 8;
    localparam int RL     = 2;
    localparam int WU     = 8;
    localparam int CNT_W  = 4;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     en;
    logic                     clear;
    logic                     halt;
    logic [NUM_CH-1:0]        ren;
    logic [NUM_CH*ADDR_W-1:0] raddr;
    logic [NUM_CH*DATA_W-1:0] dut_d;
    logic [NUM_CH*DATA_W-1:0] ref_d;
    logic                     checking;
    logic                     err;
    logic [NUM_CH-1:0]        err_ch;
    logic [CNT_W-1:0]         cnt;
    logic                     cap_valid;
    logic [1:0]               cap_ch;
    logic [ADDR_W-1:0]        cap_addr;
    logic [DATA_W-1:0]        cap_dut;
    logic [DATA_W-1:0]        cap_ref;

    int n_run  = 0;
    int n_fail = 0;

    servisia_mem_checker #(
        .NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
        .READ_LATENCY(RL), .WARMUP_CYCLES(WU), .CNT_W(CNT_W)
    ) u_dut (
        .clk_i(clk), .rst_i(rst), .en_i(en), .clear_i(clear), .halt_on_err_i(halt),
        .ren_i(ren), .raddr_i(raddr), .dut_rdata_i(dut_d), .ref_rdata_i(ref_d),
        .checking_o(checking), .err_o(err), .err_ch_o(err_ch), .mismatch_cnt_o(cnt),
        .cap_valid_o(cap_valid), .cap_ch_o(cap_ch), .cap_addr_o(cap_addr),
        .cap_dut_o(cap_dut), .cap_ref_o(cap_ref)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_cap(input string tag, input logic v, input logic [1:0] ch,
                           input logic [19:0] a, input logic [7:0] d, input logic [7:0] r);
`ifdef SERVISIA_MEMCHK_CAPTURE_EN
        chk({tag, "_valid"}, 32'(cap_valid), 32'(v));
        chk({tag, "_ch"},    32'(cap_ch),    32'(ch));
        chk({tag, "_addr"},  32'(cap_addr),  32'(a));
        chk({tag, "_dut"},   32'(cap_dut),   32'(d));
        chk({tag, "_ref"},   32'(cap_ref),   32'(r));
`else
        chk({tag, "_valid_off"}, 32'(cap_valid), 32'(v & 1'b0));
        chk({tag, "_addr_off"},  32'({cap_ch, cap_addr, cap_dut, cap_ref}), 32'(ch & 2'b0 & a[1:0] & d[1:0] & r[1:0]));
`endif
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; clear = 1'b0; halt = 1'b0;
        ren = '0; raddr = '0; dut_d = '0; ref_d = '0;
        tick;
        tick;
        chk("rst_checking", 32'(checking), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_err_ch", 32'(err_ch), 32'd0);
        chk("rst_cnt", 32'(cnt), 32'd0);
        chk_cap("rst_cap", 1'b0, 2'd0, 20'h0, 8'h0, 8'h0);

        // Warmup: mismatching reads on ch0 whose compare cycles all fall in WARMUP
        rst = 1'b0;
        dut_d = 32'h0000_0013;
        ref_d = 32'h0000_0093;
        ren = 4'b0001;
        for (int k = 1; k <= 7; k++) begin
            tick;
            if (k == 6) ren = '0;
            chk("warmup_checking", 32'(checking), 32'd0);
        end
        tick;
        chk("warmup_done_checking", 32'(checking), 32'd1);
        chk("warmup_no_err", 32'(err), 32'd0);
        chk("warmup_no_cnt", 32'(cnt), 32'd0);

        // Single mismatch at 0x00010, latency 2: compared 2 cycles later, visible 3 later
        tick;
        raddr[19:0] = 20'h00010;
        ren = 4'b0001;
        tick;
        ren = '0;
        tick;
        chk("single_compare_cycle_err", 32'(err), 32'd0);
        tick;
        chk("single_err", 32'(err), 32'd1);
        chk("single_err_ch", 32'(err_ch), 32'h1);
        chk("single_cnt", 32'(cnt), 32'd1);
        chk_cap("single_cap", 1'b1, 2'd0, 20'h00010, 8'h13, 8'h93);

        clear = 1'b1;
        tick;
        clear = 1'b0;
        chk("clear_err", 32'(err), 32'd0);
        chk("clear_cnt", 32'(cnt), 32'd0);
        chk("clear_checking", 32'(checking), 32'd1);
        chk_cap("clear_cap", 1'b0, 2'd0, 20'h0, 8'h0, 8'h0);

        // 100 matching reads on all channels
        for (int i = 0; i < 100; i++) begin
            ren   = 4'hF;
            raddr = {4{20'(i)}};
            dut_d = {4{8'(i)}};
            ref_d = {4{8'(i)}};
            tick;
            chk("match_checking", 32'(checking), 32'd1);
        end
        ren = '0;
        tick; tick; tick;
        chk("match_err", 32'(err), 32'd0);
        chk("match_cnt", 32'(cnt), 32'd0);

        // Simultaneous mismatch on channels 1 and 3
        dut_d = 32'h44_33_22_11;
        ref_d = 32'hC4_33_A2_11;
        raddr = {20'h00103, 20'h00102, 20'h00101, 20'h00100};
        ren = 4'hF;
        tick;
        ren = '0;
        tick;
        chk("multi_compare_cycle_cnt", 32'(cnt), 32'd0);
        tick;
        chk("multi_cnt", 32'(cnt), 32'd2);
        chk("multi_err_ch", 32'(err_ch), 32'b1010);
        chk("multi_err", 32'(err), 32'd1);
        chk_cap("multi_cap", 1'b1, 2'd1, 20'h00101, 8'h22, 8'hA2);

        // Saturation: 20 more reads, +2 per compare, must stop at 15
        raddr = {20'h00203, 20'h00202, 20'h00201, 20'h00200};
        ren = 4'hF;
        for (int k = 1; k <= 20; k++) begin
            tick;
            if (k == 20) ren = '0;
            if (k == 8) chk("sat_cnt_14", 32'(cnt), 32'd14);
            if (k == 9) chk("sat_cnt_15", 32'(cnt), 32'd15);
        end
        tick; tick; tick;
        chk("sat_cnt_hold", 32'(cnt), 32'd15);
        chk("sat_err_ch", 32'(err_ch), 32'b1010);
        chk_cap("sat_cap_hold", 1'b1, 2'd1, 20'h00101, 8'h22, 8'hA2);

        // Halt on error: three ch1 mismatches, only the first counts
        clear = 1'b1;
        halt  = 1'b1;
        tick;
        clear = 1'b0;
        chk("halt_pre_cnt", 32'(cnt), 32'd0);
        ren = 4'b0010;
        tick;
        tick;
        chk("halt_compare_checking", 32'(checking), 32'd1);
        tick;
        ren = '0;
        chk("halt_checking_low", 32'(checking), 32'd0);
        chk("halt_cnt_1", 32'(cnt), 32'd1);
        tick; tick; tick;
        chk("halt_cnt_hold", 32'(cnt), 32'd1);
        chk("halt_checking_hold", 32'(checking), 32'd0);
        chk("halt_err_ch", 32'(err_ch), 32'b0010);

        clear = 1'b1;
        tick;
        clear = 1'b0;
        chk("unhalt_checking", 32'(checking), 32'd1);
        chk("unhalt_cnt", 32'(cnt), 32'd0);
        chk("unhalt_err", 32'(err), 32'd0);

        // Mismatch coincident with clear is discarded and does not halt
        ren = 4'b0010;
        tick;
        ren = '0;
        tick;
        clear = 1'b1;
        tick;
        clear = 1'b0;
        chk("coinc_cnt", 32'(cnt), 32'd0);
        chk("coinc_err", 32'(err), 32'd0);
        chk("coinc_checking", 32'(checking), 32'd1);

        // en_i low at issue: read never compared even if en_i returns high
        en  = 1'b0;
        ren = 4'b0010;
        tick;
        en  = 1'b1;
        ren = '0;
        tick; tick; tick;
        chk("en_gate_cnt", 32'(cnt), 32'd0);
        chk("en_gate_err", 32'(err), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/servisia_mem_checker.md
# servisia_mem_checker

Synthesizable lockstep read-data checker for servisia memory subsystems. It compares the read data of up to NUM_CH memory ports on the DUT against a shadow reference memory, and tracks the read-request pipeline for a configurable read latency. It reports sticky error flags, a saturating mismatch count and an optional first-mismatch capture. It sits beside the flash/SRAM ports in simulation and FPGA bring-up builds, in place of free-running testbench comparisons.

## Interface
Parameters:
- NUM_CH, 1: number of independent read ports checked.
- ADDR_W, 20: read address width per channel.
- DATA_W, 8: read data width per channel.
- READ_LATENCY, 1: cycles from accepted read (ren) to valid rdata; legal range 1..8.
- WARMUP_CYCLES, 0: cycles after reset during which no comparison is made.
- CNT_W, 16: mismatch counter width.

Ports:
- clk_i  in  1  clock; all logic on rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- en_i  in  1  check enable; sampled alongside ren_i.
- clear_i  in  1  synchronous clear of flags, counter, capture and HALTED state.
- halt_on_err_i  in  1  stop checking after the first mismatch.
- ren_i  in  NUM_CH  per-channel read strobe.
- raddr_i  in  NUM_CH*ADDR_W  per-channel read address; channel c occupies bits [c*ADDR_W +: ADDR_W].
- dut_rdata_i  in  NUM_CH*DATA_W  DUT read data, packed the same way.
- ref_rdata_i  in  NUM_CH*DATA_W  reference read data, packed the same way.
- checking_o  out  1  high while in CHECKING.
- err_o  out  1  sticky: any mismatch since reset/clear.
- err_ch_o  out  NUM_CH  per-channel sticky mismatch flags.
- mismatch_cnt_o  out  CNT_W  saturating mismatch count.
- cap_valid_o, cap_ch_o (clog2(NUM_CH) bits, min 1), cap_addr_o (ADDR_W), cap_dut_o (DATA_W), cap_ref_o (DATA_W)  out  first-mismatch record.

## Operation
- Issue pipeline: per channel, a READ_LATENCY-deep shift register carries {ren_i & en_i, raddr_i}. Its output stage marks the compare cycle for that read.
- Compare stage: channel c mismatches when the stage-valid bit is set, dut_rdata != ref_rdata and the state is CHECKING.
- FSM states: WARMUP, CHECKING, HALTED.
  - Reset enters WARMUP if WARMUP_CYCLES>0, else CHECKING.
  - WARMUP -> CHECKING after WARMUP_CYCLES cycles, using a down-counter.
  - CHECKING -> HALTED on any mismatch when halt_on_err_i=1.
  - HALTED -> CHECKING on clear_i.
  - clear_i in WARMUP has no effect on the state.
- Counter: adds the popcount of mismatching channels each cycle and saturates at 2^CNT_W-1. It never wraps.
- err_ch_o[c] is set on a channel c mismatch. err_o is the OR of err_ch_o.
- Pipeline advances in every state. Reads issued during WARMUP or HALTED are dropped at the compare stage, not replayed.
- Simultaneous mismatches on several channels: all err_ch_o bits are set and the count increments by the full popcount. Capture takes the lowest-indexed channel.
- clear_i coincident with a mismatch: clear wins and the mismatch is discarded.
- Reset mid-operation: pipeline valid bits, flags, counter and capture are cleared immediately (asynchronously).

## Timing
- Reset values: checking_o = (WARMUP_CYCLES==0); all other outputs 0.
- A read accepted in cycle T is compared at T+READ_LATENCY.
- Flags, count and capture update on the edge ending the compare cycle, so they are visible at T+READ_LATENCY+1.
- checking_o is registered and falls in the cycle after the halting mismatch. No further mismatches are counted from that cycle.
- clear_i takes effect on the next edge, with all results 0 the following cycle.
- Warmup: checking_o rises exactly WARMUP_CYCLES cycles after reset deassertion.

## Configuration
- SERVISIA_MEMCHK_CAPTURE_EN defined:
  - cap_* registers are implemented.
  - They load on the first mismatch after reset/clear and then hold until clear_i or reset.
  - cap_valid_o rises together with err_o.
- Undefined:
  - No capture registers are built.
  - cap_* ports remain and are tied to 0.
  - Flags and counter are unaffected.

## Test plan
- NUM_CH=1, READ_LATENCY=1, matching data on 100 reads -> err_o=0, mismatch_cnt_o=0, checking_o=1 throughout.
- Read at addr 0x00010 in cycle 5 with dut=0x13, ref=0x93 -> err_o=1 from cycle 7. With CAPTURE_EN, cap_addr_o=0x00010, cap_dut_o=0x13, cap_ref_o=0x93.
- NUM_CH=4, mismatch on channels 1 and 3 in the same cycle -> count +2, err_ch_o=4'b1010, cap_ch_o=1.
- CNT_W=4, 20 consecutive mismatches -> mismatch_cnt_o holds at 15.
- WARMUP_CYCLES=8, mismatching reads in cycles 0..7 -> no error. Mismatch in cycle 9 -> err_o=1 at cycle 10.
- halt_on_err_i=1, mismatch then further mismatches -> count stays 1 and checking_o=0. clear_i -> count 0, checking_o=1 next cycle. Mismatch coincident with clear_i -> count 0.
